irq_sequencer: RTL and testbench

//  Interrupt scheduler for the 8-bit OISC program counter. Arbitrates up to

---
 rtl/irq_sequencer.sv | 133 +++++++++++++
 tb/tb_irq_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - fixed-priority nesting interrupt sequencer driving PC redirects
module irq_sequencer #(
    parameter int          NIRQ       = 4,
    parameter int          DEPTH      = 4,
    parameter logic [15:0] VEC_BASE   = 16'h0010,
    parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_req,
    input  logic            mask_wr,
    input  logic [NIRQ-1:0] mask_in,
    output logic [NIRQ-1:0] mask_q,
    input  logic            step,
    input  logic [15:0]     pc_next,
    input  logic            ret,
    output logic            redirect,
    output logic [15:0]     redirect_pc,
    output logic [NIRQ-1:0] irq_ack,
    output logic [3:0]      active_lvl,
    output logic            busy,
    output logic            err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SERVICE, S_VECTOR} state_e;

    state_e          state_q, state_d;
    logic [3:0]      depth_q, depth_d;
    logic [3:0]      active_lvl_q, active_lvl_d;
    logic            redirect_q, redirect_d;
    logic [15:0]     redirect_pc_q, redirect_pc_d;
    logic [NIRQ-1:0] irq_ack_q, irq_ack_d;
    logic            err_q, err_d;
    logic [NIRQ-1:0] mask_d;

    logic [15:0]     pc_stk_q  [DEPTH];
    logic [3:0]      lvl_stk_q [DEPTH];

    logic [NIRQ-1:0] eligible;
    logic [3:0]      winner;
    logic            full, push, pop;
    logic [AW-1:0]   push_idx, top_idx;

    // Scan from lowest priority upward so the lowest eligible index wins.
    always_comb begin
        eligible = '0;
        winner   = 4'(NIRQ);
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq_req[i] && mask_q[i] && (4'(i) < active_lvl_q)) begin
                eligible[i] = 1'b1;
                winner      = 4'(i);
            end
        end
    end

    assign full     = (depth_q == 4'(DEPTH));
    assign pop      = ret && (state_q == S_SERVICE);
    assign push     = (state_q != S_VECTOR) && step && (|eligible) && !full && !ret;
    assign push_idx = depth_q[AW-1:0];
    assign top_idx  = AW'(depth_q - 4'd1);

    always_comb begin
        state_d       = state_q;
        depth_d       = depth_q;
        active_lvl_d  = active_lvl_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        irq_ack_d     = '0;
        err_d         = err_q;
        mask_d        = mask_wr ? mask_in : mask_q;

        if (ret && (state_q != S_SERVICE)) begin
            err_d = 1'b1;
        end

        if (pop) begin
            depth_d       = depth_q - 4'd1;
            active_lvl_d  = lvl_stk_q[top_idx];
            redirect_d    = 1'b1;
            redirect_pc_d = pc_stk_q[top_idx];
            state_d       = (depth_q == 4'd1) ? S_IDLE : S_SERVICE;
        end else if (push) begin
            depth_d       = depth_q + 4'd1;
            active_lvl_d  = winner;
            redirect_d    = 1'b1;
            redirect_pc_d = VEC_BASE + {12'd0, winner} * VEC_STRIDE;
            irq_ack_d     = NIRQ'(1) << winner;
            state_d       = S_VECTOR;
        end else if (state_q == S_VECTOR) begin
            state_d = S_SERVICE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            depth_q       <= 4'd0;
            active_lvl_q  <= 4'(NIRQ);
            redirect_q    <= 1'b0;
            redirect_pc_q <= 16'd0;
            irq_ack_q     <= '0;
            err_q         <= 1'b0;
            mask_q        <= '0;
        end else begin
            state_q       <= state_d;
            depth_q       <= depth_d;
            active_lvl_q  <= active_lvl_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            irq_ack_q     <= irq_ack_d;
            err_q         <= err_d;
            mask_q        <= mask_d;
        end
    end

    // Stack contents need no reset; depth_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            pc_stk_q[push_idx]  <= pc_next;
            lvl_stk_q[push_idx] <= active_lvl_q;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign irq_ack     = irq_ack_q;
    assign active_lvl  = active_lvl_q;
    assign busy        = (depth_q != 4'd0);
    assign err         = err_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - directed and randomized checks of irq_sequencer against a queue model
module tb_irq_sequencer;

    localparam int NIRQ       = 4;
    localparam int DEPTH      = 2;
    localparam int VEC_BASE   = 16'h0010;
    localparam int VEC_STRIDE = 16'h0008;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq_req;
    logic            mask_wr;
    logic [NIRQ-1:0] mask_in;
    logic [NIRQ-1:0] mask_q;
    logic            step;
    logic [15:0]     pc_next;
    logic            ret;
    logic            redirect;
    logic [15:0]     redirect_pc;
    logic [NIRQ-1:0] irq_ack;
    logic [3:0]      active_lvl;
    logic            busy;
    logic            err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: return stack as queues, service level, one-cycle vector flag.
    int          stk_pc [$];
    int          stk_lvl[$];
    int          m_lvl;
    bit          m_vec;
    bit          m_redir;
    int          m_rpc;
    int          m_ack;
    bit          m_err;
    int          m_mask;

    irq_sequencer #(
        .NIRQ      (NIRQ),
        .DEPTH     (DEPTH),
        .VEC_BASE  (16'h0010),
        .VEC_STRIDE(16'h0008)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_req    (irq_req),
        .mask_wr    (mask_wr),
        .mask_in    (mask_in),
        .mask_q     (mask_q),
        .step       (step),
        .pc_next    (pc_next),
        .ret        (ret),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .irq_ack    (irq_ack),
        .active_lvl (active_lvl),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        int  w;
        bit  nv;
        @(posedge clk);
        if (!rst) begin
            stk_pc.delete();
            stk_lvl.delete();
            m_lvl   = NIRQ;
            m_vec   = 1'b0;
            m_redir = 1'b0;
            m_rpc   = 0;
            m_ack   = 0;
            m_err   = 1'b0;
            m_mask  = 0;
        end else begin
            nv      = 1'b0;
            w       = -1;
            m_redir = 1'b0;
            m_ack   = 0;
            if (ret) begin
                if (!m_vec && stk_pc.size() > 0) begin
                    m_rpc   = stk_pc.pop_back();
                    m_lvl   = stk_lvl.pop_back();
                    m_redir = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end else if (step && !m_vec && stk_pc.size() < DEPTH) begin
                for (int i = NIRQ - 1; i >= 0; i--)
                    if (irq_req[i] && m_mask[i] && i < m_lvl) w = i;
                if (w >= 0) begin
                    stk_pc.push_back(int'(pc_next));
                    stk_lvl.push_back(m_lvl);
                    m_lvl   = w;
                    m_redir = 1'b1;
                    m_rpc   = (VEC_BASE + w * VEC_STRIDE) % 65536;
                    m_ack   = 1 << w;
                    nv      = 1'b1;
                end
            end
            m_vec = nv;
            if (mask_wr) m_mask = int'(mask_in);
        end
        #1;
        chk("redirect", 32'(redirect), 32'(m_redir));
        chk("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
        chk("irq_ack", 32'(irq_ack), 32'(m_ack));
        chk("active_lvl", 32'(active_lvl), 32'(m_lvl));
        chk("busy", 32'(busy), 32'(stk_pc.size() != 0));
        chk("err", 32'(err), 32'(m_err));
        chk("mask_q", 32'(mask_q), 32'(m_mask));
    endtask

    task automatic drive(input logic [NIRQ-1:0] irq, input logic st, input logic [15:0] pc, input logic r);
        irq_req = irq;
        step    = st;
        pc_next = pc;
        ret     = r;
    endtask

    initial begin
        rst = 1'b0; irq_req = '0; mask_wr = 1'b0; mask_in = '0;
        step = 1'b0; pc_next = 16'd0; ret = 1'b0;

        tick();
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_pc", 32'(redirect_pc), 32'd0);
        chk("rst_lvl", 32'(active_lvl), 32'd4);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mask", 32'(mask_q), 32'd0);

        rst = 1'b1; mask_wr = 1'b1; mask_in = 4'b1111;
        tick();
        mask_wr = 1'b0;

        drive(4'b0100, 1'b1, 16'h0123, 1'b0); tick();
        chk("t1_redirect", 32'(redirect), 32'd1);
        chk("t1_pc", 32'(redirect_pc), 32'h0020);
        chk("t1_ack", 32'(irq_ack), 32'b0100);
        chk("t1_lvl", 32'(active_lvl), 32'd2);
        drive(4'b0000, 1'b0, 16'h0124, 1'b0); tick();

        drive(4'b0001, 1'b1, 16'h0200, 1'b0); tick();
        chk("t2_vec0", 32'(redirect_pc), 32'h0010);
        drive(4'b0000, 1'b0, 16'h0201, 1'b0); tick();
        drive(4'b0000, 1'b0, 16'h0201, 1'b1); tick();
        chk("t2_ret1_pc", 32'(redirect_pc), 32'h0200);
        chk("t2_ret1_lvl", 32'(active_lvl), 32'd2);
        drive(4'b0000, 1'b0, 16'h0201, 1'b0); tick();
        drive(4'b0000, 1'b0, 16'h0201, 1'b1); tick();
        chk("t2_ret2_pc", 32'(redirect_pc), 32'h0123);
        chk("t2_ret2_lvl", 32'(active_lvl), 32'd4);
        chk("t2_ret2_busy", 32'(busy), 32'd0);

        drive(4'b0010, 1'b1, 16'h0300, 1'b0); tick();
        chk("t3_vec1", 32'(redirect_pc), 32'h0018);
        drive(4'b0000, 1'b0, 16'h0301, 1'b0); tick();
        drive(4'b1000, 1'b1, 16'h0301, 1'b0); tick();
        chk("t3_lower", 32'(redirect), 32'd0);
        drive(4'b0010, 1'b1, 16'h0301, 1'b0); tick();
        chk("t3_equal", 32'(redirect), 32'd0);
        drive(4'b0000, 1'b0, 16'h0301, 1'b1); tick();
        chk("t3_ret_pc", 32'(redirect_pc), 32'h0300);
        drive(4'b0000, 1'b0, 16'h0301, 1'b0); tick();

        drive(4'b1000, 1'b1, 16'h0400, 1'b0); tick();
        chk("t4_vec3", 32'(redirect_pc), 32'h0028);
        drive(4'b0000, 1'b0, 16'h0401, 1'b0); tick();
        drive(4'b0100, 1'b1, 16'h0410, 1'b0); tick();
        chk("t4_vec2", 32'(redirect_pc), 32'h0020);
        drive(4'b0000, 1'b0, 16'h0411, 1'b0); tick();
        drive(4'b0001, 1'b1, 16'h0420, 1'b0); tick();
        chk("t4_full1", 32'(redirect), 32'd0);
        tick();
        chk("t4_full2", 32'(redirect), 32'd0);
        drive(4'b0001, 1'b1, 16'h0420, 1'b1); tick();
        chk("t5_retwin", 32'(redirect_pc), 32'h0410);
        chk("t5_retwin_ack", 32'(irq_ack), 32'd0);
        chk("t5_retwin_lvl", 32'(active_lvl), 32'd3);
        drive(4'b0001, 1'b1, 16'h0420, 1'b0); tick();
        chk("t4_late_pc", 32'(redirect_pc), 32'h0010);
        chk("t4_late_ack", 32'(irq_ack), 32'b0001);
        drive(4'b0000, 1'b0, 16'h0421, 1'b0); tick();
        drive(4'b0000, 1'b0, 16'h0421, 1'b1); tick();
        chk("t4_pop_a", 32'(redirect_pc), 32'h0420);
        tick();
        chk("t4_pop_b", 32'(redirect_pc), 32'h0400);
        chk("t4_pop_lvl", 32'(active_lvl), 32'd4);
        tick();
        chk("t5_ret_idle_redir", 32'(redirect), 32'd0);
        chk("t5_ret_idle_err", 32'(err), 32'd1);

        drive(4'b0100, 1'b1, 16'h0500, 1'b0); rst = 1'b0; tick();
        chk("t6_redirect", 32'(redirect), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_mask", 32'(mask_q), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        rst = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) != 0);
            mask_wr = ($urandom_range(0, 9) == 0);
            mask_in = NIRQ'($urandom);
            irq_req = NIRQ'($urandom);
            step    = ($urandom_range(0, 1) == 1);
            pc_next = 16'($urandom);
            ret     = ($urandom_range(0, 6) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
